// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC mode encoding,
// the sequential step and the word-alignment helper.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'b00,
    MODE_BRANCH = 2'b01,
    MODE_JUMP   = 2'b10,
    MODE_RET    = 2'b11
  } pc_mode_e;

  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned MAX_WORD = 64;

  typedef logic [MAX_WORD-1:0] max_word_t;

  // Clears the byte-offset bits so every fetch address is word-aligned.
  function automatic max_word_t align_mask(input max_word_t addr);
    return addr & ~max_word_t'(3);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch controller (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int WORD_SIZE = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic                 stall;
  logic [1:0]           mode;
  logic                 take;
  logic [WORD_SIZE-1:0] offset;
  logic [WORD_SIZE-1:0] target;
  logic                 push;
  logic                 exc;
  logic                 eret;
  logic                 clr_err;
  logic [WORD_SIZE-1:0] pc_out;
  logic [WORD_SIZE-1:0] epc_out;
  logic                 in_exc;
  logic [CNT_W-1:0]     ras_count;
  logic                 ras_ovf;
  logic                 ras_udf;

  modport master (
    output stall, mode, take, offset, target, push, exc, eret, clr_err,
    input  pc_out, epc_out, in_exc, ras_count, ras_ovf, ras_udf
  );

  modport slave (
    input  stall, mode, take, offset, target, push, exc, eret, clr_err,
    output pc_out, epc_out, in_exc, ras_count, ras_ovf, ras_udf
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// push+pop together replaces the top in place.
module pc_ras #(
  parameter int WORD_SIZE = 32,
  parameter int RAS_DEPTH = 4,
  localparam int CNT_W = $clog2(RAS_DEPTH + 1),
  localparam int PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  output logic [WORD_SIZE-1:0] top_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  logic [WORD_SIZE-1:0] entries_q [RAS_DEPTH];
  logic [PTR_W-1:0]     top_q, top_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     next_ptr, prev_ptr, wr_ptr;
  logic                 wr_en, empty, full, pop_ok;

  assign next_ptr = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign prev_ptr = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(RAS_DEPTH));
  assign pop_ok   = pop_i & ~empty;
  assign top_o    = entries_q[top_q];
  assign count_o  = count_q;

  // When full, the slot after top holds the oldest entry, so advancing overwrites it.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q;
    ovf_o   = 1'b0;
    udf_o   = pop_i & empty;
    if (push_i && pop_ok) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      top_d  = next_ptr;
      wr_ptr = next_ptr;
      wr_en  = 1'b1;
      if (full) ovf_o = 1'b1;
      else      count_d = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      top_d   = prev_ptr;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= PTR_W'(RAS_DEPTH - 1);
      count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      if (wr_en) entries_q[wr_ptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, exception entry/exit with a saved
// EPC, and sticky return-stack error flags.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   RAS_DEPTH  = 4,
  parameter logic [WORD_SIZE-1:0] RESET_ADDR = '0,
  parameter logic [WORD_SIZE-1:0] EXC_VECTOR = WORD_SIZE'('h80)
) (
  input logic     clk,
  input logic     reset,
  pc_unit_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam max_word_t            MASK_EXT = align_mask({MAX_WORD{1'b1}});
  localparam logic [WORD_SIZE-1:0] PC_MASK  = MASK_EXT[WORD_SIZE-1:0];

  logic [WORD_SIZE-1:0] pc_q, pc_d, epc_q, epc_d, next_raw, pc_plus4;
  logic                 in_exc_q, in_exc_d;
  logic                 ras_ovf_q, ras_ovf_d, ras_udf_q, ras_udf_d;
  logic                 ras_push, ras_pop, ras_ovf_stb, ras_udf_stb;
  logic [WORD_SIZE-1:0] ras_top;
  logic [CNT_W-1:0]     ras_count;
  pc_mode_e             mode_sel;

  assign mode_sel = pc_mode_e'(bus.mode);
  assign pc_plus4 = pc_q + WORD_SIZE'(PC_STEP);

  pc_ras #(
    .WORD_SIZE(WORD_SIZE),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .reset  (reset),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .wdata_i(pc_plus4),
    .top_o  (ras_top),
    .count_o(ras_count),
    .ovf_o  (ras_ovf_stb),
    .udf_o  (ras_udf_stb)
  );

  // Priority: exc > stall > eret > mode/push; only the last slot touches the RAS.
  always_comb begin
    next_raw = pc_q;
    epc_d    = epc_q;
    in_exc_d = in_exc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.exc) begin
      next_raw = EXC_VECTOR;
      if (!in_exc_q) begin
        epc_d    = pc_q;
        in_exc_d = 1'b1;
      end
    end else if (bus.stall) begin
      next_raw = pc_q;
    end else if (bus.eret && in_exc_q) begin
      next_raw = epc_q;
      in_exc_d = 1'b0;
    end else if (bus.eret) begin
      next_raw = pc_plus4;
    end else begin
      ras_push = bus.push;
      case (mode_sel)
        MODE_SEQ:    next_raw = pc_plus4;
        MODE_BRANCH: next_raw = bus.take ? pc_plus4 + bus.offset : pc_plus4;
        MODE_JUMP:   next_raw = bus.target;
        MODE_RET: begin
          ras_pop  = 1'b1;
          next_raw = (ras_count == '0) ? pc_plus4 : ras_top;
        end
        default:     next_raw = pc_plus4;
      endcase
    end
    pc_d      = next_raw & PC_MASK;
    ras_ovf_d = (ras_ovf_q & ~bus.clr_err) | ras_ovf_stb;
    ras_udf_d = (ras_udf_q & ~bus.clr_err) | ras_udf_stb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_ADDR;
      epc_q     <= '0;
      in_exc_q  <= 1'b0;
      ras_ovf_q <= 1'b0;
      ras_udf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      in_exc_q  <= in_exc_d;
      ras_ovf_q <= ras_ovf_d;
      ras_udf_q <= ras_udf_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.epc_out   = epc_q;
  assign bus.in_exc    = in_exc_q;
  assign bus.ras_count = ras_count;
  assign bus.ras_ovf   = ras_ovf_q;
  assign bus.ras_udf   = ras_udf_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the successor to the fixed-increment PC. It computes the next fetch address from a mode select, including sequential, conditional relative branch, absolute jump and subroutine return. It keeps a circular return-address stack (RAS) for call/return and handles exception entry/exit with a saved EPC. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- WORD_SIZE, 32, address/data width; must be ≥ 8
- RAS_DEPTH, 4, return-stack entries; must be ≥ 2
- RESET_ADDR, 0, PC value while in reset; word-aligned
- EXC_VECTOR, 32'h80, exception entry address; word-aligned

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle
- mode  in  2  next-PC select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RET
- take  in  1  branch condition; used only in BRANCH
- offset  in  WORD_SIZE  signed byte offset for BRANCH
- target  in  WORD_SIZE  absolute address for JUMP
- push  in  1  call: push pc_out+4 onto the RAS
- exc  in  1  exception request
- eret  in  1  return from exception
- clr_err  in  1  clear sticky error flags
- pc_out  out  WORD_SIZE  current PC
- epc_out  out  WORD_SIZE  saved exception PC
- in_exc  out  1  exception handler active
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_ovf  out  1  sticky flag: push dropped the oldest entry
- ras_udf  out  1  sticky flag: RET issued on an empty stack

## Operation
- Reset (reset=0, asynchronous) sets:
  - pc_out = RESET_ADDR
  - epc_out = 0, in_exc = 0
  - ras_count = 0, ras_ovf = 0, ras_udf = 0
- Per-edge priority, highest first: exc > stall > eret > mode/push.
- exc:
  - pc ← EXC_VECTOR.
  - If in_exc=0: epc ← pc and in_exc ← 1.
  - If in_exc=1 (nested): pc still vectors; epc and in_exc are unchanged.
  - The RAS is untouched.
- stall: pc, epc, RAS and flags all hold; push and mode are ignored; clr_err still acts.
- eret:
  - If in_exc=1: pc ← epc and in_exc ← 0.
  - If in_exc=0: behaves as SEQ.
- Mode behaviour:
  - SEQ: pc ← pc+4.
  - BRANCH: pc ← pc+4+offset when take=1, otherwise pc+4.
  - JUMP: pc ← target.
  - RET on a non-empty RAS: pc ← top entry; pop.
  - RET on an empty RAS: pc ← pc+4; ras_udf ← 1.
- Arithmetic is modulo 2^WORD_SIZE (wrap-around, no flag). Bits [1:0] of every next-PC value are forced to 0.
- push:
  - Writes pc+4 (the current pc plus 4) onto the RAS. It is independent of mode; a call is JUMP+push or BRANCH+push.
  - Full RAS: the oldest entry is overwritten circularly, ras_count stays at RAS_DEPTH, and ras_ovf ← 1.
  - push with RET in the same cycle: the popped top supplies the target and the new value replaces it; ras_count is unchanged.
- clr_err clears ras_ovf/ras_udf. If a new error occurs in the same cycle, the set wins.

## Timing
- All state updates on the rising edge of clk; outputs are registered, with no combinational path from inputs to outputs.
- Next-PC latency is 1 cycle: inputs sampled at edge N appear on pc_out after edge N.
- Reset deassertion is synchronised externally; the first update occurs on the first edge with reset=1.
- Reset asserted mid-operation immediately clears everything listed above, including RAS contents.
- Sticky flags and ras_count update on the same edge as the pc.

## Structure
- Package pc_unit_pkg holds:
  - mode constants MODE_SEQ/BRANCH/JUMP/RET
  - the PC_STEP=4 constant
  - the alignment mask function
- Sub-module pc_ras: circular stack with top pointer, count, push/pop/replace and overflow/underflow strobes. It is parametrised on WORD_SIZE and RAS_DEPTH.
- pc_unit contains the next-PC mux, the exception/EPC logic and the sticky flags.

## Test plan
- Reset and sequential fetch: reset low with RESET_ADDR=0, then release; 3 SEQ cycles → pc_out 4, 8, 12; all flags 0.
- Branch and stall:
  - At pc=0x10, BRANCH take=1 offset=-8 → 0x0C.
  - take=0 → 0x14.
  - stall held 2 cycles → pc is unchanged.
- Call/return:
  - JUMP+push target=0x100 at pc=0x20 → pc=0x100, ras_count=1.
  - RET → pc=0x24, ras_count=0.
  - A further RET → pc=0x28, ras_udf=1.
- RAS overflow: 5 pushes with RAS_DEPTH=4 → ras_count=4, ras_ovf=1; 4 RETs return pushed values 5, 4, 3, 2 in order; clr_err → ras_ovf=0.
- Exception:
  - exc at pc=0x40 → pc=0x80, epc=0x40, in_exc=1.
  - Nested exc → epc stays 0x40.
  - eret → pc=0x40, in_exc=0.
  - exc+stall in the same cycle → the exception is taken.
- Wrap and reset mid-operation:
  - pc=0xFFFFFFFC with SEQ → pc=0.
  - reset asserted between edges → pc_out=0 immediately.
